// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo -- PS/2 device-to-host receiver with a first-word-fall-through
// byte FIFO, running entirely in the clk domain.
//
// Ports:
//   clk, reset        system clock (rising edge), async active-high reset
//   ps2_clk, ps2_data raw asynchronous PS/2 pins
//   rd_data/rd_valid/rd_ready  FIFO read port
//   fifo_count        occupied FIFO entries
//   busy              receiver is inside a frame (state != IDLE)
//   parity_err, frame_err, overflow  one-cycle error strobes
//
// Read handshake: rd_valid is high whenever the FIFO holds a byte and
// rd_data then shows the head byte; the head is consumed on a rising clk
// edge where rd_valid && rd_ready, and rd_data/rd_valid show the next
// entry in the following cycle.
//
// Build option: define PS2_RX_PARITY_CHECK_EN to check odd parity; when
// undefined the parity bit is ignored and parity_err is tied low.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ps2_clk,
  input  logic                             ps2_data,
  output logic [7:0]                       rd_data,
  output logic                             rd_valid,
  input  logic                             rd_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             busy,
  output logic                             parity_err,
  output logic                             frame_err,
  output logic                             overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Pin synchronisers and registered falling-edge detect. Registering the
  // edge (and the data bit with it) gives the stop-edge-to-rd_valid latency
  // of SYNC_STAGES+2 cycles.
  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q, edge_q, bit_q;
  logic                   clk_s, data_s;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      edge_q      <= 1'b0;
      bit_q       <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_s;
      edge_q      <= clk_prev_q & ~clk_s;
      bit_q       <= data_s;
    end
  end

  // Frame decoder state
  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        push, frame_err_d, parity_err_d, parity_ok;
`ifdef PS2_RX_PARITY_CHECK_EN
  logic        acc_q, acc_d;   // running XOR of data bits, then parity bit
  assign parity_ok = acc_q;
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      timer_q   <= '0;
`ifdef PS2_RX_PARITY_CHECK_EN
      acc_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      timer_q   <= timer_d;
`ifdef PS2_RX_PARITY_CHECK_EN
      acc_q     <= acc_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    push         = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
    acc_d        = acc_q;
`endif
    if (state_q == S_IDLE || edge_q) timer_d = '0;
    else                             timer_d = timer_q + TW'(1);

    case (state_q)
      S_IDLE: if (edge_q && !bit_q) begin
        state_d   = S_DATA;
        bit_cnt_d = 3'd0;
`ifdef PS2_RX_PARITY_CHECK_EN
        acc_d     = 1'b0;
`endif
      end
      S_DATA: if (edge_q) begin
        shift_d[bit_cnt_q] = bit_q;
`ifdef PS2_RX_PARITY_CHECK_EN
        acc_d = acc_q ^ bit_q;
`endif
        if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        else                   bit_cnt_d = bit_cnt_q + 3'd1;
      end
      S_PARITY: if (edge_q) begin
        // Folding the parity bit into the accumulator leaves 1 for odd parity.
`ifdef PS2_RX_PARITY_CHECK_EN
        acc_d = acc_q ^ bit_q;
`endif
        state_d = S_STOP;
      end
      S_STOP: if (edge_q) begin
        state_d = S_IDLE;
        if (!bit_q)         frame_err_d  = 1'b1;
        else if (parity_ok) push         = 1'b1;
        else                parity_err_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Stalled frame: no falling edge for TIMEOUT_CYCLES cycles.
    if (state_q != S_IDLE && !edge_q && timer_q == TW'(TIMEOUT_CYCLES-1)) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
      timer_d     = '0;
    end
  end

  assign busy = (state_q != S_IDLE);

  // FWFT FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, pop, do_push;
  logic          frame_err_q, parity_err_q, overflow_q;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign rd_valid = (count_q != '0);
  assign pop      = rd_valid && rd_ready;
  assign do_push  = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overflow_q   <= push && full && !pop;
    end
  end

  // Head entry is masked so rd_data reads 8'h00 while the FIFO is empty.
  assign rd_data    = rd_valid ? mem[rd_ptr_q] : 8'h00;
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
`ifdef PS2_RX_PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
  logic unused_parity;
  assign unused_parity = parity_err_q | parity_err_d;
`endif

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver that runs entirely in the system `clk` domain. It synchronises the raw `ps2_clk`/`ps2_data` pins and decodes 11-bit frames (start, 8 data LSB-first, odd parity, stop). Good bytes are buffered in a first-word-fall-through FIFO with a valid/ready read port. Malformed frames, stalled frames and FIFO overflow are reported on one-cycle error strobes. It sits between the keyboard connector pins and the host-side register/bus interface.

## Interface
- `FIFO_DEPTH`, 8: byte entries; power of two, >= 2.
- `SYNC_STAGES`, 2: synchroniser flops on each PS/2 pin; >= 2.
- `TIMEOUT_CYCLES`, 2000: max `clk` cycles between falling `ps2_clk` edges inside a frame; >= 2.

- `clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous.
- `rd_data` output 8: FIFO head byte; valid only while `rd_valid`=1.
- `rd_valid` output 1: FIFO not empty.
- `rd_ready` input 1: consumer accepts head; pop occurs when `rd_valid && rd_ready`.
- `fifo_count` output $clog2(FIFO_DEPTH+1): occupied entries.
- `busy` output 1: receiver state != IDLE.
- `parity_err` output 1: one-cycle strobe, parity mismatch.
- `frame_err` output 1: one-cycle strobe, bad stop bit or timeout.
- `overflow` output 1: one-cycle strobe, good byte dropped because FIFO full.

## Operation
- Sync: `SYNC_STAGES` flops per pin, reset to 1. An edge is detected when the previous synced `ps2_clk` was 1 and the current one is 0. Synced `ps2_data` is sampled in the same cycle.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on a detected edge, except timeout.
  - IDLE: data=0 -> DATA, bit_cnt=0, parity acc=0. Data=1 -> stay in IDLE silently.
  - DATA: shift bit into `shift[bit_cnt]` and XOR it into acc. After the 8th bit (bit_cnt==7) -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP:
    - data=0 -> `frame_err`, byte discarded.
    - data=1 with parity ok -> push byte.
    - Any stop bit value returns the FSM to IDLE.
- Parity ok means the XOR of the 8 data bits and the parity bit equals 1 (odd parity).
- Timeout: a counter clears on each detected edge and increments otherwise while not IDLE. Reaching `TIMEOUT_CYCLES` -> IDLE, `frame_err` strobe, partial byte discarded. The counter is held at 0 in IDLE.
- FIFO: circular buffer with separate read and write pointers plus `fifo_count`.
  - Push when full and no pop in the same cycle -> byte dropped, `overflow` strobe, FIFO unchanged.
  - Push and pop in the same cycle when full -> both occur, count unchanged.
  - Push and pop in the same cycle when empty -> push only, since `rd_valid` was 0.
  - Pointers wrap at `FIFO_DEPTH`.
- Reset values: all strobes 0, `busy` 0, `rd_valid` 0, `fifo_count` 0, `rd_data` 8'h00. FSM in IDLE, FIFO emptied.
- Reset mid-frame aborts the frame with no strobe. Decoding restarts at the next start bit after reset is released.

## Timing
- Detected-edge to FSM update: 1 cycle.
- Push to `rd_valid`: `rd_valid` rises on the clk edge that performs the push.
- Pin-level latency: falling `ps2_clk` of the stop bit to `rd_valid`=1 is `SYNC_STAGES`+2 cycles, with an empty FIFO.
- Error strobes assert for exactly one cycle, in the same cycle `rd_valid` would have risen.
- Pop: `rd_data` and `rd_valid` update in the cycle after the accepting edge; FWFT, no read latency.
- `parity_err`, `frame_err` and `overflow` are mutually exclusive per frame.
- PS/2 clock 10–16.7 kHz; `clk` must be >= 20x the PS/2 clock. Settle at least `SYNC_STAGES` cycles after reset release.

## Configuration
- `PS2_RX_PARITY_CHECK_EN`:
  - Defined: parity is checked as above; a mismatch with a good stop bit discards the byte and strobes `parity_err`.
  - Undefined: the parity bit is sampled and ignored, every frame with a good stop bit is pushed, and `parity_err` is tied to 0.

## Test plan
- Send frame for 8'h1C with parity 0 and stop 1 -> `rd_valid`=1, `rd_data`=8'h1C, `fifo_count`=1, no strobes. Then `rd_ready`=1 for 1 cycle -> `rd_valid`=0.
- Send 8'h1C with parity 1 -> with macro: `parity_err` 1-cycle pulse, `fifo_count`=0. Without macro: byte pushed.
- Send 8'hF0 with stop bit 0 -> `frame_err` pulse, no push. Next good frame 8'h5A -> pushed correctly.
- Stop `ps2_clk` after 4 data bits for `TIMEOUT_CYCLES`+10 cycles -> `frame_err` pulse, `busy`=0. Following good frame 8'h29 -> pushed.
- Fill with `FIFO_DEPTH` bytes 8'h01..8'h08, then send 8'h09 -> `overflow` pulse, count 8, reads return 8'h01..8'h08 in order. Repeat with `rd_ready` held high during the 9th push -> count stays 8, 8'h09 last.
- Assert `reset` during bit 5 of a frame -> all outputs at reset values, FIFO empty. Next full frame 8'h76 -> pushed.
